// File: rtl/k_and_s_pkg.sv
// Shared types and encodings for the K&S processor: instruction decode,
// controller states and ALU operation codes.
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP,
        I_LOAD,
        I_STORE,
        I_MOVE,
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_BRANCH,
        I_BZERO,
        I_BNZERO,
        I_BNEG,
        I_BNNEG,
        I_BOV,
        I_BNOV,
        I_HALT
    } decoded_instruction_type;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_LOAD,
        S_STORE,
        S_ALU,
        S_HALT
    } ctrl_state_type;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    function automatic logic is_alu_instr(input decoded_instruction_type instr);
        case (instr)
            I_MOVE, I_ADD, I_SUB, I_AND, I_OR: is_alu_instr = 1'b1;
            default:                           is_alu_instr = 1'b0;
        endcase
    endfunction

    // MOVE rides on OR: the datapath presents the source on both ALU inputs.
    function automatic logic [1:0] alu_op_of(input decoded_instruction_type instr);
        case (instr)
            I_AND:         alu_op_of = OP_AND;
            I_OR, I_MOVE:  alu_op_of = OP_OR;
            I_SUB:         alu_op_of = OP_SUB;
            default:       alu_op_of = OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_branch_eval.sv
// Combinational branch condition evaluation against the registered ALU flags.
module branch_eval
    import k_and_s_pkg::*;
(
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    is_branch,
    output logic                    take_branch
);

    // No instruction in this ISA branches on carry-out.
    logic unused_carry;
    assign unused_carry = unsigned_overflow;

    always_comb begin
        is_branch   = 1'b1;
        take_branch = 1'b0;
        case (decoded_instruction)
            I_BRANCH: take_branch = 1'b1;
            I_BZERO:  take_branch = zero_op;
            I_BNZERO: take_branch = ~zero_op;
            I_BNEG:   take_branch = neg_op;
            I_BNNEG:  take_branch = ~neg_op;
            I_BOV:    take_branch = signed_overflow;
            I_BNOV:   take_branch = ~signed_overflow;
            default:  is_branch   = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle controller for the K&S datapath: fetch, decode, then one
// execute cycle for load/store/ALU instructions; halts until reset.
module control_unit
    import k_and_s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt
);

    ctrl_state_type state_reg;
    ctrl_state_type state_next;
    logic           is_branch;
    logic           take_branch;

    branch_eval u_branch_eval (
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .is_branch           (is_branch),
        .take_branch         (take_branch)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        operation        = OP_ADD;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halt             = 1'b0;

        case (state_reg)
            S_IDLE: begin
                state_next = S_FETCH;
            end

            S_FETCH: begin
                addr_sel   = 1'b0;
                ir_enable  = 1'b1;
                state_next = S_DECODE;
            end

            // PC advances here so execute cycles can use the IR's mem_addr.
            S_DECODE: begin
                if (decoded_instruction == I_HALT) begin
                    state_next = S_HALT;
                end else if (is_branch) begin
                    pc_enable  = 1'b1;
                    branch     = take_branch;
                    state_next = S_FETCH;
                end else begin
                    pc_enable = 1'b1;
                    if (decoded_instruction == I_LOAD) begin
                        state_next = S_LOAD;
                    end else if (decoded_instruction == I_STORE) begin
                        state_next = S_STORE;
                    end else if (is_alu_instr(decoded_instruction)) begin
                        state_next = S_ALU;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end

            S_LOAD: begin
                addr_sel         = 1'b1;
                c_sel            = 1'b1;
                write_reg_enable = 1'b1;
                state_next       = S_FETCH;
            end

            S_STORE: begin
                addr_sel         = 1'b1;
                ram_write_enable = 1'b1;
                state_next       = S_FETCH;
            end

            S_ALU: begin
                c_sel            = 1'b0;
                operation        = alu_op_of(decoded_instruction);
                write_reg_enable = 1'b1;
                flags_reg_enable = 1'b1;
                state_next       = S_FETCH;
            end

            S_HALT: begin
                halt       = 1'b1;
                state_next = S_HALT;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: drives decoded instructions
// and flags cycle by cycle and compares the packed control output vector.
module tb_control_unit;
    import k_and_s_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    decoded_instruction_type decoded_instruction = I_NOP;
    logic                    zero_op = 1'b0;
    logic                    neg_op = 1'b0;
    logic                    unsigned_overflow = 1'b0;
    logic                    signed_overflow = 1'b0;
    logic                    branch, pc_enable, ir_enable, addr_sel, c_sel;
    logic [1:0]              operation;
    logic                    write_reg_enable, flags_reg_enable, ram_write_enable, halt;

    // {branch, pc_enable, ir_enable, addr_sel, c_sel, operation, wr, flags, ram_we, halt}
    logic [10:0] outs;
    assign outs = {branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
                   write_reg_enable, flags_reg_enable, ram_write_enable, halt};

    localparam logic [10:0] O_NONE = 11'h000;
    localparam logic [10:0] O_BR   = 11'h400;
    localparam logic [10:0] O_PC   = 11'h200;
    localparam logic [10:0] O_IR   = 11'h100;
    localparam logic [10:0] O_AS   = 11'h080;
    localparam logic [10:0] O_CS   = 11'h040;
    localparam logic [10:0] O_ADD  = 11'h000;
    localparam logic [10:0] O_AND  = 11'h010;
    localparam logic [10:0] O_OR   = 11'h020;
    localparam logic [10:0] O_SUB  = 11'h030;
    localparam logic [10:0] O_WR   = 11'h008;
    localparam logic [10:0] O_FL   = 11'h004;
    localparam logic [10:0] O_RAM  = 11'h002;
    localparam logic [10:0] O_HALT = 11'h001;

    int n_checks = 0;
    int n_fail   = 0;

    control_unit dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .operation           (operation),
        .write_reg_enable    (write_reg_enable),
        .flags_reg_enable    (flags_reg_enable),
        .ram_write_enable    (ram_write_enable),
        .halt                (halt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (outs !== O_NONE) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got %b want %b", i, outs, O_NONE);
            end
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (outs !== O_NONE) begin
            n_fail++;
            $display("FAIL reset_idle: got %b want %b", outs, O_NONE);
        end
        tick();
        n_checks++;
        if (outs !== O_IR) begin
            n_fail++;
            $display("FAIL reset_first_fetch: got %b want %b", outs, O_IR);
        end
        $display("reset: idle then fetch, outs=%b", outs);
    endtask

    task automatic test_load;
        tick();
        decoded_instruction = I_LOAD;
        #1;
        n_checks++;
        if (outs !== O_PC) begin
            n_fail++;
            $display("FAIL load_decode: got %b want %b", outs, O_PC);
        end
        tick();
        n_checks++;
        if (outs !== (O_AS | O_CS | O_WR)) begin
            n_fail++;
            $display("FAIL load_exec: got %b want %b", outs, O_AS | O_CS | O_WR);
        end
        tick();
        n_checks++;
        if (outs !== O_IR) begin
            n_fail++;
            $display("FAIL load_refetch: got %b want %b", outs, O_IR);
        end
        $display("load: 3-cycle LOAD sequence, back in fetch outs=%b", outs);
    endtask

    task automatic test_sub_bzero;
        tick();
        decoded_instruction = I_SUB;
        #1;
        n_checks++;
        if (outs !== O_PC) begin
            n_fail++;
            $display("FAIL sub_decode: got %b want %b", outs, O_PC);
        end
        tick();
        n_checks++;
        if (outs !== (O_SUB | O_WR | O_FL)) begin
            n_fail++;
            $display("FAIL sub_alu: got %b want %b", outs, O_SUB | O_WR | O_FL);
        end
        // Flags register updates at the end of S_ALU; zero result seen next decode.
        zero_op = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            tick();
            n_checks++;
            if (outs !== O_IR) begin
                n_fail++;
                $display("FAIL bzero_fetch[%0d]: got %b want %b", pass, outs, O_IR);
            end
            tick();
            decoded_instruction = I_BZERO;
            #1;
            n_checks++;
            if (outs !== (pass == 0 ? (O_PC | O_BR) : O_PC)) begin
                n_fail++;
                $display("FAIL bzero_decode[%0d]: got %b want %b", pass, outs,
                         pass == 0 ? (O_PC | O_BR) : O_PC);
            end
            $display("bzero pass %0d: zero_op=%b outs=%b", pass, zero_op, outs);
            zero_op = 1'b0;
        end
        tick();
        n_checks++;
        if (outs !== O_IR) begin
            n_fail++;
            $display("FAIL bzero_after: got %b want %b", outs, O_IR);
        end
    endtask

    task automatic test_store;
        tick();
        decoded_instruction = I_STORE;
        #1;
        n_checks++;
        if (outs !== O_PC) begin
            n_fail++;
            $display("FAIL store_decode: got %b want %b", outs, O_PC);
        end
        tick();
        n_checks++;
        if (outs !== (O_AS | O_RAM)) begin
            n_fail++;
            $display("FAIL store_exec: got %b want %b", outs, O_AS | O_RAM);
        end
        $display("store: exec outs=%b", outs);
        tick();
        n_checks++;
        if (outs !== O_IR) begin
            n_fail++;
            $display("FAIL store_refetch: got %b want %b", outs, O_IR);
        end
    endtask

    task automatic test_add_bov;
        tick();
        decoded_instruction = I_ADD;
        #1;
        tick();
        n_checks++;
        if (outs !== (O_ADD | O_WR | O_FL)) begin
            n_fail++;
            $display("FAIL add_alu: got %b want %b", outs, O_ADD | O_WR | O_FL);
        end
        signed_overflow = 1'b1;
        tick();
        tick();
        decoded_instruction = I_BOV;
        #1;
        n_checks++;
        if (outs !== (O_PC | O_BR)) begin
            n_fail++;
            $display("FAIL bov_taken: got %b want %b", outs, O_PC | O_BR);
        end
        tick();
        tick();
        decoded_instruction = I_BNOV;
        #1;
        n_checks++;
        if (outs !== O_PC) begin
            n_fail++;
            $display("FAIL bnov_untaken: got %b want %b", outs, O_PC);
        end
        $display("add/bov: overflow branch taken, bnov untaken outs=%b", outs);
        signed_overflow = 1'b0;
        tick();
    endtask

    typedef struct {
        decoded_instruction_type instr;
        logic [10:0]             op_bits;
    } alu_vec_t;

    task automatic test_alu_ops;
        alu_vec_t vecs [5] = '{
            '{I_MOVE, O_OR},
            '{I_AND,  O_AND},
            '{I_OR,   O_OR},
            '{I_ADD,  O_ADD},
            '{I_SUB,  O_SUB}
        };
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (outs !== O_IR) begin
                n_fail++;
                $display("FAIL alu_fetch[%0d]: got %b want %b", i, outs, O_IR);
            end
            tick();
            decoded_instruction = vecs[i].instr;
            #1;
            tick();
            n_checks++;
            if (outs !== (vecs[i].op_bits | O_WR | O_FL)) begin
                n_fail++;
                $display("FAIL alu_op[%s]: got %b want %b", vecs[i].instr.name(), outs,
                         vecs[i].op_bits | O_WR | O_FL);
            end
            $display("alu %s: outs=%b", vecs[i].instr.name(), outs);
            tick();
        end
    endtask

    typedef struct {
        decoded_instruction_type instr;
        logic [3:0]              flags;   // {zero, neg, carry, signed ov}
        logic                    taken;
    } br_vec_t;

    task automatic test_back_to_back_branches;
        br_vec_t vecs [15] = '{
            '{I_BRANCH, 4'b0000, 1'b1},
            '{I_BZERO,  4'b1000, 1'b1},
            '{I_BZERO,  4'b0111, 1'b0},
            '{I_BNZERO, 4'b0111, 1'b1},
            '{I_BNZERO, 4'b1000, 1'b0},
            '{I_BNEG,   4'b0100, 1'b1},
            '{I_BNEG,   4'b1011, 1'b0},
            '{I_BNNEG,  4'b1011, 1'b1},
            '{I_BNNEG,  4'b0100, 1'b0},
            '{I_BOV,    4'b0001, 1'b1},
            '{I_BOV,    4'b1110, 1'b0},
            '{I_BNOV,   4'b1110, 1'b1},
            '{I_BNOV,   4'b0001, 1'b0},
            '{I_NOP,    4'b1111, 1'b0},
            '{I_BOV,    4'b0010, 1'b0}
        };
        logic [10:0] want;
        for (int i = 0; i < 15; i++) begin
            n_checks++;
            if (outs !== O_IR) begin
                n_fail++;
                $display("FAIL br_fetch[%0d]: got %b want %b", i, outs, O_IR);
            end
            {zero_op, neg_op, unsigned_overflow, signed_overflow} = vecs[i].flags;
            tick();
            decoded_instruction = vecs[i].instr;
            #1;
            want = vecs[i].taken ? (O_PC | O_BR) : O_PC;
            n_checks++;
            if (outs !== want) begin
                n_fail++;
                $display("FAIL br_decode[%0d %s]: got %b want %b", i,
                         vecs[i].instr.name(), outs, want);
            end
            $display("branch %s flags=%b: outs=%b", vecs[i].instr.name(), vecs[i].flags, outs);
            tick();
        end
        {zero_op, neg_op, unsigned_overflow, signed_overflow} = 4'b0000;
    endtask

    task automatic test_reset_mid_instr;
        tick();
        decoded_instruction = I_ADD;
        #1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (outs !== O_NONE) begin
            n_fail++;
            $display("FAIL reset_mid_alu: got %b want %b", outs, O_NONE);
        end
        tick();
        rst_n = 1'b1;
        #1;
        tick();
        n_checks++;
        if (outs !== O_IR) begin
            n_fail++;
            $display("FAIL reset_mid_refetch: got %b want %b", outs, O_IR);
        end
        $display("reset mid-instruction: restart at fetch outs=%b", outs);
    endtask

    task automatic test_halt;
        tick();
        decoded_instruction = I_HALT;
        #1;
        n_checks++;
        if (outs !== O_NONE) begin
            n_fail++;
            $display("FAIL halt_decode: got %b want %b", outs, O_NONE);
        end
        tick();
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (outs !== O_HALT) begin
                n_fail++;
                $display("FAIL halt_hold[%0d]: got %b want %b", i, outs, O_HALT);
            end
            decoded_instruction = (i % 2 == 0) ? I_LOAD : I_BRANCH;
            tick();
        end
        $display("halt: held 20 cycles outs=%b", outs);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (outs !== O_NONE) begin
            n_fail++;
            $display("FAIL halt_async_reset: got %b want %b", outs, O_NONE);
        end
        tick();
        rst_n = 1'b1;
        #1;
        tick();
        n_checks++;
        if (outs !== O_IR) begin
            n_fail++;
            $display("FAIL halt_restart: got %b want %b", outs, O_IR);
        end
        $display("halt: async reset released, fetch outs=%b", outs);
    endtask

    initial begin
        test_reset();
        test_load();
        test_sub_bzero();
        test_store();
        test_add_bov();
        test_alu_ops();
        test_back_to_back_branches();
        test_reset_mid_instr();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
